// File: rtl/cursor_overlay_pkg.sv
// Shared definitions for the text-cursor overlay stage.
// Character-cell geometry, register map, reset values of the cursor
// registers, and the packed pixel-stream record that travels from pixgen
// through the overlay to vga_output.
package cursor_overlay_pkg;

  // Character-cell geometry and screen size in cells.
  localparam int CHAR_W       = 8;
  localparam int CHAR_H       = 16;
  localparam int COLS         = 80;
  localparam int ROWS         = 30;
  localparam int BLINK_FRAMES = 16;

  // Counter widths.
  localparam int PX_W    = $clog2(CHAR_W);
  localparam int COL_W   = 7;
  localparam int ROW_W   = 5;
  localparam int SCAN_W  = $clog2(CHAR_H);
  localparam int BLINK_W = $clog2(BLINK_FRAMES);

  // Register map for the host write port.
  localparam logic [1:0] ADDR_COL   = 2'd0;
  localparam logic [1:0] ADDR_ROW   = 2'd1;
  localparam logic [1:0] ADDR_SHAPE = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  // Cursor shape: scanline range within the cell, inclusive.
  typedef struct packed {
    logic [SCAN_W-1:0] scan_last;
    logic [SCAN_W-1:0] scan_first;
  } shape_t;

  typedef struct packed {
    logic blink_en;
    logic enable;
  } ctrl_t;

  // Underline-style cursor on the last two scanlines, blinking, enabled.
  localparam shape_t SHAPE_RST = 8'hFE;
  localparam ctrl_t  CTRL_RST  = 2'b11;

  // One pixel of the video stream; colour nibbles are {red,green,blue,intense}.
  typedef struct packed {
    logic       nvis;
    logic       pixel;
    logic [3:0] fg;
    logic [3:0] bg;
  } pix_bus_t;

  localparam pix_bus_t PIX_BLANK = '{nvis: 1'b1, pixel: 1'b0, fg: 4'h0, bg: 4'h0};

  // True when the scanline lies inside the cursor shape. An inverted range
  // (first > last) never matches, which gives "no cursor" for free.
  function automatic logic scan_in_shape(input logic [SCAN_W-1:0] scan,
                                         input shape_t           shape);
    return (scan >= shape.scan_first) && (scan <= shape.scan_last);
  endfunction

endpackage

// File: rtl/cursor_blink.sv
// Cursor blink generator.
// Counts frame-start pulses and toggles the visible phase every
// BLINK_FRAMES frames. The phase starts as "shown" out of reset.
// Ports:
//   clk        dot clock
//   nrst       synchronous active-low reset
//   frameStart one-cycle pulse at the start of each frame
//   phase      1 = cursor shown, 0 = cursor hidden
module cursor_blink
  import cursor_overlay_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic frameStart,
  output logic phase
);

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (frameStart) begin
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would create
  // order-dependent simulation and a mismatch with the synthesized netlist.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/cursor_overlay.sv
// Text-cursor overlay between pixgen and vga_output.
// Tracks the character cell and scanline of the incoming pixel from the
// visibility strobe, inverts the pixel inside the host-programmed cursor
// cell, and re-registers the whole stream with one clock of latency.
// Ports:
//   clk, nrst                 dot clock, synchronous active-low reset
//   regWr/regAddr/regWrData   host cursor-register write port
//   frameStart                one-cycle pulse before the first visible line
//   nVisIn, pixelIn, fg*/bg*  pixel stream from pixgen
//   nVisOut, pixelOut, fg*Out/bg*Out  same stream, delayed one clock
module cursor_overlay
  import cursor_overlay_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       regWr,
  input  logic [1:0] regAddr,
  input  logic [7:0] regWrData,
  input  logic       frameStart,
  input  logic       nVisIn,
  input  logic       pixelIn,
  input  logic       fgRed,
  input  logic       fgGreen,
  input  logic       fgBlue,
  input  logic       fgIntense,
  input  logic       bgRed,
  input  logic       bgGreen,
  input  logic       bgBlue,
  input  logic       bgIntense,
  output logic       nVisOut,
  output logic       pixelOut,
  output logic       fgRedOut,
  output logic       fgGreenOut,
  output logic       fgBlueOut,
  output logic       fgIntenseOut,
  output logic       bgRedOut,
  output logic       bgGreenOut,
  output logic       bgBlueOut,
  output logic       bgIntenseOut
);

  localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(CHAR_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(CHAR_H - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

  // Cursor registers.
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  shape_t           shape_q, shape_d;
  ctrl_t            ctrl_q, ctrl_d;

  // Position of the pixel currently presented on the input.
  logic [PX_W-1:0]   px_q, px_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              nvis_prev_q;

  pix_bus_t in_bus, out_d, out_q;
  logic     blink_phase;
  logic     cursor_hit;
  logic     line_end;

  cursor_blink u_blink (
    .clk        (clk),
    .nrst       (nrst),
    .frameStart (frameStart),
    .phase      (blink_phase)
  );

  // Register file: upper data bits beyond each field's width are dropped.
  // NOTE: every always_comb output gets its default first, so no path through
  // the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    shape_d   = shape_q;
    ctrl_d    = ctrl_q;
    if (regWr) begin
      case (regAddr)
        ADDR_COL:   cur_col_d = regWrData[COL_W-1:0];
        ADDR_ROW:   cur_row_d = regWrData[ROW_W-1:0];
        ADDR_SHAPE: shape_d   = shape_t'(regWrData);
        ADDR_CTRL:  ctrl_d    = ctrl_t'(regWrData[1:0]);
        default:    ;
      endcase
    end
  end

  // Visible-to-blank transition marks the end of a scanline.
  assign line_end = !nvis_prev_q && nVisIn;

  // Position counters. Column and row saturate so mismatched timing can
  // never wrap the cursor onto the opposite screen edge.
  always_comb begin
    px_d   = px_q;
    col_d  = col_q;
    scan_d = scan_q;
    row_d  = row_q;
    if (frameStart) begin
      px_d   = '0;
      col_d  = '0;
      scan_d = '0;
      row_d  = '0;
    end else if (line_end) begin
      px_d  = '0;
      col_d = '0;
      if (scan_q == SCAN_LAST) begin
        scan_d = '0;
        if (row_q != ROW_LAST) row_d = row_q + 1'b1;
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end else if (!nVisIn) begin
      if (px_q == PX_LAST) begin
        px_d = '0;
        if (col_q != COL_LAST) col_d = col_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  // Out-of-range column/row never compares equal, so they simply never hit.
  assign cursor_hit = ctrl_q.enable
                    & (blink_phase | ~ctrl_q.blink_en)
                    & (col_q == cur_col_q)
                    & (row_q == cur_row_q)
                    & scan_in_shape(scan_q, shape_q)
                    & ~nVisIn;

  assign in_bus = '{nvis:  nVisIn,
                    pixel: pixelIn,
                    fg:    {fgRed, fgGreen, fgBlue, fgIntense},
                    bg:    {bgRed, bgGreen, bgBlue, bgIntense}};

  always_comb begin
    out_d       = in_bus;
    out_d.pixel = pixelIn ^ cursor_hit;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cur_col_q   <= '0;
      cur_row_q   <= '0;
      shape_q     <= SHAPE_RST;
      ctrl_q      <= CTRL_RST;
      px_q        <= '0;
      col_q       <= '0;
      scan_q      <= '0;
      row_q       <= '0;
      nvis_prev_q <= 1'b1;
      out_q       <= PIX_BLANK;
    end else begin
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
      shape_q     <= shape_d;
      ctrl_q      <= ctrl_d;
      px_q        <= px_d;
      col_q       <= col_d;
      scan_q      <= scan_d;
      row_q       <= row_d;
      nvis_prev_q <= nVisIn;
      out_q       <= out_d;
    end
  end

  assign nVisOut      = out_q.nvis;
  assign pixelOut     = out_q.pixel;
  assign fgRedOut     = out_q.fg[3];
  assign fgGreenOut   = out_q.fg[2];
  assign fgBlueOut    = out_q.fg[1];
  assign fgIntenseOut = out_q.fg[0];
  assign bgRedOut     = out_q.bg[3];
  assign bgGreenOut   = out_q.bg[2];
  assign bgBlueOut    = out_q.bg[1];
  assign bgIntenseOut = out_q.bg[0];

endmodule

// File: tb/tb_cursor_overlay.sv
// Self-checking bench for cursor_overlay: a table of directed single-cycle
// vectors followed by frame-level sequences for the cursor position, the
// last cell, out-of-range settings, blinking and reset behaviour.
module tb_cursor_overlay;

  logic       clk = 1'b0;
  logic       nrst;
  logic       regWr;
  logic [1:0] regAddr;
  logic [7:0] regWrData;
  logic       frameStart;
  logic       nVisIn;
  logic       pixelIn;
  logic       fgRed, fgGreen, fgBlue, fgIntense;
  logic       bgRed, bgGreen, bgBlue, bgIntense;
  logic       nVisOut, pixelOut;
  logic       fgRedOut, fgGreenOut, fgBlueOut, fgIntenseOut;
  logic       bgRedOut, bgGreenOut, bgBlueOut, bgIntenseOut;

  int checks = 0;
  int errors = 0;

  // Cursor as the bench believes it is programmed.
  int   m_cc, m_cr, m_first, m_last;
  logic m_en, m_shown;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic       nvis;
    logic       pix;
    logic [7:0] col;
    logic       exp_nvis;
    logic       exp_pix;
    logic [7:0] exp_col;
  } vec_t;

  vec_t vecs[14];

  always #20 clk = ~clk;

  cursor_overlay dut (
    .clk          (clk),
    .nrst         (nrst),
    .regWr        (regWr),
    .regAddr      (regAddr),
    .regWrData    (regWrData),
    .frameStart   (frameStart),
    .nVisIn       (nVisIn),
    .pixelIn      (pixelIn),
    .fgRed        (fgRed),
    .fgGreen      (fgGreen),
    .fgBlue       (fgBlue),
    .fgIntense    (fgIntense),
    .bgRed        (bgRed),
    .bgGreen      (bgGreen),
    .bgBlue       (bgBlue),
    .bgIntense    (bgIntense),
    .nVisOut      (nVisOut),
    .pixelOut     (pixelOut),
    .fgRedOut     (fgRedOut),
    .fgGreenOut   (fgGreenOut),
    .fgBlueOut    (fgBlueOut),
    .fgIntenseOut (fgIntenseOut),
    .bgRedOut     (bgRedOut),
    .bgGreenOut   (bgGreenOut),
    .bgBlueOut    (bgBlueOut),
    .bgIntenseOut (bgIntenseOut)
  );

  function automatic logic [9:0] out_vec();
    return {nVisOut, pixelOut, fgRedOut, fgGreenOut, fgBlueOut, fgIntenseOut,
            bgRedOut, bgGreenOut, bgBlueOut, bgIntenseOut};
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic set_inputs(input logic nvis, input logic fs, input logic wr,
                            input logic [1:0] addr, input logic [7:0] data,
                            input logic pix, input logic [7:0] col);
    nVisIn     = nvis;
    frameStart = fs;
    regWr      = wr;
    regAddr    = addr;
    regWrData  = data;
    pixelIn    = pix;
    {fgRed, fgGreen, fgBlue, fgIntense, bgRed, bgGreen, bgBlue, bgIntense} = col;
  endtask

  // One clock with random pixel/colours; expects the same values back one
  // clock later with the pixel inverted when hit is set.
  task automatic drive(input string name, input logic nvis, input logic fs,
                       input logic wr, input logic [1:0] addr,
                       input logic [7:0] data, input logic hit);
    logic [7:0] colours;
    logic       pix;
    colours = 8'($urandom);
    pix     = 1'($urandom);
    set_inputs(nvis, fs, wr, addr, data, pix, colours);
    @(posedge clk);
    #1;
    check(name, out_vec(), {nvis, pix ^ hit, colours});
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [7:0] data);
    drive("regwrite", 1'b1, 1'b0, 1'b1, addr, data, 1'b0);
  endtask

  task automatic frame_start();
    drive("framestart", 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  // Two reset cycles with random inputs; output must be blank each time.
  task automatic do_reset();
    nrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_inputs(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                 8'($urandom), 1'($urandom), 8'($urandom));
      @(posedge clk);
      #1;
      check("reset", out_vec(), 10'b10_0000_0000);
    end
    nrst = 1'b1;
  endtask

  function automatic logic exp_hit(input int x, input int l);
    int scan;
    scan = l % 16;
    return m_en && m_shown && (x / 8 == m_cc) && (l / 16 == m_cr) &&
           (scan >= m_first) && (scan <= m_last);
  endfunction

  task automatic run_line(input int l, input int npix, input int nblank);
    for (int x = 0; x < npix; x++)
      drive("pixel", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, exp_hit(x, l));
    for (int b = 0; b < nblank; b++)
      drive("blank", 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  initial begin
    // wr addr data nvis pix col | exp_nvis exp_pix exp_col
    vecs[0]  = '{1'b1, 2'd3, 8'h01, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5}; // ctrl=01
    vecs[1]  = '{1'b1, 2'd2, 8'hF0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C}; // shape all scans
    vecs[2]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 8'h0F}; // px0 hit
    vecs[3]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 8'hF0}; // px1 hit
    vecs[4]  = '{1'b1, 2'd3, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 8'h81}; // disable, not yet
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E}; // disabled now
    vecs[6]  = '{1'b1, 2'd3, 8'h01, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55}; // re-enable, not yet
    vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 8'hAA}; // px5 hit
    vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'h11}; // px6 hit
    vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 8'h22}; // px7 hit
    vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 8'h44}; // col1 no hit
    vecs[11] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 8'h99}; // line end
    vecs[12] = '{1'b1, 2'd0, 8'h81, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00}; // col=1 (bit7 dropped)
    vecs[13] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF}; // col0 no longer hit

    nrst = 1'b0;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      set_inputs(vecs[i].nvis, 1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data,
                 vecs[i].pix, vecs[i].col);
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), out_vec(),
            {vecs[i].exp_nvis, vecs[i].exp_pix, vecs[i].exp_col});
    end

    // Default cursor with blinking off: cells (0,0), scanlines 14..15.
    do_reset();
    write_reg(2'd3, 8'h01);
    m_en = 1'b1; m_shown = 1'b1; m_cc = 0; m_cr = 0; m_first = 14; m_last = 15;
    frame_start();
    for (int l = 0; l < 16; l++) run_line(l, 640, 4);
    for (int l = 16; l < 18; l++) run_line(l, 8, 2);
    // Reset in the middle of a visible line blanks the next output.
    run_line(18, 3, 0);
    do_reset();

    // Last cell, full-height block; upper data bits must be ignored.
    write_reg(2'd0, 8'hCF);
    write_reg(2'd1, 8'hFD);
    write_reg(2'd2, 8'hF0);
    write_reg(2'd3, 8'h01);
    m_en = 1'b1; m_shown = 1'b1; m_cc = 79; m_cr = 29; m_first = 0; m_last = 15;
    frame_start();
    for (int l = 0; l < 464; l++) run_line(l, 1, 1);
    for (int l = 464; l < 480; l++) run_line(l, 640, 3);

    // Column out of range: never hits.
    write_reg(2'd0, 8'd100);
    write_reg(2'd1, 8'd0);
    m_cc = 100; m_cr = 0;
    frame_start();
    for (int l = 0; l < 16; l++) run_line(l, 640, 3);

    // Inverted shape (start 10 > end 3): never hits.
    write_reg(2'd0, 8'd0);
    write_reg(2'd2, 8'h3A);
    m_cc = 0; m_first = 10; m_last = 3;
    frame_start();
    for (int l = 0; l < 16; l++) run_line(l, 16, 2);

    // Cursor disabled entirely: pure one-clock pass-through.
    write_reg(2'd2, 8'hF0);
    write_reg(2'd3, 8'h00);
    m_en = 1'b0; m_first = 0; m_last = 15;
    frame_start();
    for (int l = 0; l < 16; l++) run_line(l, 16, 2);

    // Blink from reset: frame 0 directly follows reset, frames 1..63 begin
    // with a frame-start pulse. Shown 0-15, hidden 16-31, shown 32-47, hidden 48-63.
    do_reset();
    m_en = 1'b1; m_cc = 0; m_cr = 0; m_first = 14; m_last = 15;
    for (int f = 0; f < 64; f++) begin
      if (f > 0) frame_start();
      m_shown = ((f / 16) % 2) == 0;
      for (int l = 0; l < 16; l++) run_line(l, 8, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
